// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, funct codes,
// ALU operation codes, the controller state encoding and datapath mux encodings.
package mips_ctrl_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // ALU operation codes
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    // Controller states; the numeric values are visible on the debug port
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_REXEC   = 4'd6,
        S_RWB     = 4'd7,
        S_IEXEC   = 4'd8,
        S_IWB     = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    // ALU operand B select
    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC source select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct -> ALU operation decoder for R-type instructions.
// funct_valid flags the function codes the core actually implements.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_valid
);

    // Map each supported funct to its ALU code; anything else is invalid
    always_comb begin
        alucontrol  = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADDU: alucontrol = ALU_ADD;
            FN_SUBU: alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLTU: alucontrol = ALU_SLTU;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for the multicycle MIPS core. Sequences fetch, decode,
// execute, memory and write-back over one shared memory port, optionally
// stretching memory states until mem_ready. Only FETCH (ready) and BRANCH (zero)
// have input-dependent outputs.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int USE_MEM_READY = 1,
    parameter int ALUCTRL_W     = 3,
    parameter int STATE_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instr,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pcen,
    output logic                 irwrite,
    output logic                 iord,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 regdst,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic                 immext,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal,
    output logic [STATE_W-1:0]   state
);

    state_t      state_q;
    state_t      next_state;
    logic        illegal_q;
    logic        ready;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [2:0]  rtype_alu;
    logic        funct_valid;
    logic [2:0]  alu_c;
    logic        pcen_c;
    logic        irwrite_c;
    logic        memread_c;
    logic        memwrite_c;
    logic        regwrite_c;
    logic        unused_instr;

    assign op           = instr[31:26];
    assign funct        = instr[5:0];
    assign unused_instr = ^instr[25:6];

    // Without the handshake every memory access is assumed to finish in one cycle
    assign ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    alu_decoder u_alu_decoder (
        .funct       (funct),
        .alucontrol  (rtype_alu),
        .funct_valid (funct_valid)
    );

    // State register and sticky illegal flag; reset aborts any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= next_state;
            if (next_state == S_ILLEGAL) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state selection from current state, opcode/funct and memory ready
    always_comb begin
        next_state = state_q;
        case (state_q)
            S_FETCH:  next_state = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:             next_state = S_MEMADR;
                    OP_RTYPE:                 next_state = S_REXEC;
                    OP_BEQ:                   next_state = S_BRANCH;
                    OP_ADDIU, OP_ORI, OP_LUI: next_state = S_IEXEC;
                    OP_J:                     next_state = S_JUMP;
                    default:                  next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  next_state = op[3] ? S_MEMWR : S_MEMRD;
            S_MEMRD:   next_state = ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   next_state = S_FETCH;
            S_MEMWR:   next_state = ready ? S_FETCH : S_MEMWR;
            S_REXEC:   next_state = funct_valid ? S_RWB : S_ILLEGAL;
            S_RWB:     next_state = S_FETCH;
            S_IEXEC:   next_state = S_IWB;
            S_IWB:     next_state = S_FETCH;
            S_BRANCH:  next_state = S_FETCH;
            S_JUMP:    next_state = S_FETCH;
            S_ILLEGAL: next_state = S_ILLEGAL;
            default:   next_state = S_FETCH;
        endcase
    end

    // Datapath control decode per state; the five strobes are gated by reset below
    always_comb begin
        pcen_c     = 1'b0;
        irwrite_c  = 1'b0;
        memread_c  = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RT;
        immext     = 1'b0;
        pcsrc      = PC_ALU;
        alu_c      = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                memread_c = 1'b1;
                alusrcb   = SRCB_FOUR;
                pcen_c    = ready;
                irwrite_c = ready;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                iord      = 1'b1;
                memread_c = 1'b1;
            end
            S_MEMWB: begin
                regwrite_c = 1'b1;
                memtoreg   = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_c = 1'b1;
            end
            S_REXEC: begin
                alusrca = 1'b1;
                alu_c   = rtype_alu;
            end
            S_RWB: begin
                regwrite_c = 1'b1;
                regdst     = 1'b1;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                case (op)
                    OP_ORI: begin
                        alu_c  = ALU_OR;
                        immext = 1'b1;
                    end
                    OP_LUI: begin
                        alu_c  = ALU_LUI;
                        immext = 1'b1;
                    end
                    default: alu_c = ALU_ADD;
                endcase
            end
            S_IWB: begin
                regwrite_c = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                alu_c   = ALU_SUB;
                pcsrc   = PC_ALUOUT;
                pcen_c  = zero;
            end
            S_JUMP: begin
                pcsrc  = PC_JUMP;
                pcen_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcen       = pcen_c & ~reset;
    assign irwrite    = irwrite_c & ~reset;
    assign memread    = memread_c & ~reset;
    assign memwrite   = memwrite_c & ~reset;
    assign regwrite   = regwrite_c & ~reset;
    assign alucontrol = ALUCTRL_W'(alu_c);
    assign illegal    = illegal_q;
    assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. The stimulus process drives one
// cycle at a time and queues the hand-written expected state/controls; a monitor
// on the falling edge pops and compares against the selected DUT instance
// (u_dut: handshake enabled, u_dut0: handshake disabled with mem_ready tied low).
module tb_multicycle_controller;

    typedef struct {
        string       nm;
        logic [3:0]  st;
        logic [18:0] ctl;
        bit          sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;

    logic        pcen, irwrite, iord, memread, memwrite, memtoreg, regwrite, regdst, alusrca, immext, illegal;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic [3:0]  state;
    logic        pcen0, irwrite0, iord0, memread0, memwrite0, memtoreg0, regwrite0, regdst0, alusrca0, immext0, illegal0;
    logic [1:0]  alusrcb0, pcsrc0;
    logic [2:0]  alucontrol0;
    logic [3:0]  state0;
    logic [18:0] act_a, act_b;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // State numbers as exposed on the debug port
    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                           MEMWB = 4'd4, MEMWR = 4'd5, REXEC = 4'd6, RWB = 4'd7,
                           IEXEC = 4'd8, IWB = 4'd9, BRANCH = 4'd10, JUMP = 4'd11,
                           ILLEGAL = 4'd12;

    localparam logic [31:0] I_ADDU = 32'h00221821, I_LW = 32'h8C220004, I_SW = 32'hAC220004,
                            I_BEQ = 32'h10220003, I_ORI = 32'h34220FF0, I_LUI = 32'h3C011234,
                            I_J = 32'h08000010, I_BADOP = 32'hFC000000, I_SLT = 32'h0022182A;

    always #5 clk = ~clk;

    multicycle_controller u_dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .irwrite(irwrite), .iord(iord), .memread(memread), .memwrite(memwrite),
        .memtoreg(memtoreg), .regwrite(regwrite), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .immext(immext), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .illegal(illegal), .state(state)
    );

    multicycle_controller #(.USE_MEM_READY(0)) u_dut0 (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(1'b0),
        .pcen(pcen0), .irwrite(irwrite0), .iord(iord0), .memread(memread0), .memwrite(memwrite0),
        .memtoreg(memtoreg0), .regwrite(regwrite0), .regdst(regdst0), .alusrca(alusrca0),
        .alusrcb(alusrcb0), .immext(immext0), .pcsrc(pcsrc0), .alucontrol(alucontrol0),
        .illegal(illegal0), .state(state0)
    );

    assign act_a = {pcen, irwrite, iord, memread, memwrite, memtoreg, regwrite, regdst,
                    alusrca, alusrcb, immext, pcsrc, alucontrol, illegal};
    assign act_b = {pcen0, irwrite0, iord0, memread0, memwrite0, memtoreg0, regwrite0, regdst0,
                    alusrca0, alusrcb0, immext0, pcsrc0, alucontrol0, illegal0};

    // Pack named control fields in the same order as act_a/act_b
    function automatic logic [18:0] c(input logic pe, input logic irw, input logic ird, input logic mrd,
                                      input logic mwr, input logic m2r, input logic rw, input logic rd,
                                      input logic sa, input logic [1:0] sb, input logic ix,
                                      input logic [1:0] ps, input logic [2:0] alu, input logic il);
        return {pe, irw, ird, mrd, mwr, m2r, rw, rd, sa, sb, ix, ps, alu, il};
    endfunction

    // Drive one cycle of inputs and queue what the chosen DUT must show during it
    task automatic cyc(input string nm, input logic [31:0] ins, input logic z, input logic mr,
                       input logic [3:0] st, input logic [18:0] ctl, input bit sel);
        exp_t e;
        instr     = ins;
        zero      = z;
        mem_ready = mr;
        e.nm = nm; e.st = st; e.ctl = ctl; e.sel = sel;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation each cycle
    initial begin
        exp_t e;
        logic [3:0]  ast;
        logic [18:0] actl;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e    = q.pop_front();
                ast  = e.sel ? state0 : state;
                actl = e.sel ? act_b : act_a;
                checks++;
                if (ast !== e.st) begin
                    errors++;
                    $display("FAIL %s state: got %0d want %0d", e.nm, ast, e.st);
                end
                checks++;
                if (actl !== e.ctl) begin
                    errors++;
                    $display("FAIL %s controls: got %b want %b", e.nm, actl, e.ctl);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [18:0] k_fetch, k_fetch_wait, k_fetch_rst, k_decode, k_memadr, k_memrd, k_memwb,
                     k_memwr, k_rexec_add, k_rwb, k_iwb, k_ori, k_lui, k_beq1, k_beq0, k_jump, k_ill;
        //              pe irw ird mrd mwr m2r rw rd sa sb     ix ps     alu     il
        k_fetch      = c(1, 1,  0,  1,  0,  0,  0, 0, 0, 2'b01, 0, 2'b00, 3'b010, 0);
        k_fetch_wait = c(0, 0,  0,  1,  0,  0,  0, 0, 0, 2'b01, 0, 2'b00, 3'b010, 0);
        k_fetch_rst  = c(0, 0,  0,  0,  0,  0,  0, 0, 0, 2'b01, 0, 2'b00, 3'b010, 0);
        k_decode     = c(0, 0,  0,  0,  0,  0,  0, 0, 0, 2'b11, 0, 2'b00, 3'b010, 0);
        k_memadr     = c(0, 0,  0,  0,  0,  0,  0, 0, 1, 2'b10, 0, 2'b00, 3'b010, 0);
        k_memrd      = c(0, 0,  1,  1,  0,  0,  0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0);
        k_memwb      = c(0, 0,  0,  0,  0,  1,  1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0);
        k_memwr      = c(0, 0,  1,  0,  1,  0,  0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0);
        k_rexec_add  = c(0, 0,  0,  0,  0,  0,  0, 0, 1, 2'b00, 0, 2'b00, 3'b010, 0);
        k_rwb        = c(0, 0,  0,  0,  0,  0,  1, 1, 0, 2'b00, 0, 2'b00, 3'b010, 0);
        k_iwb        = c(0, 0,  0,  0,  0,  0,  1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0);
        k_ori        = c(0, 0,  0,  0,  0,  0,  0, 0, 1, 2'b10, 1, 2'b00, 3'b001, 0);
        k_lui        = c(0, 0,  0,  0,  0,  0,  0, 0, 1, 2'b10, 1, 2'b00, 3'b011, 0);
        k_beq1       = c(1, 0,  0,  0,  0,  0,  0, 0, 1, 2'b00, 0, 2'b01, 3'b110, 0);
        k_beq0       = c(0, 0,  0,  0,  0,  0,  0, 0, 1, 2'b00, 0, 2'b01, 3'b110, 0);
        k_jump       = c(1, 0,  0,  0,  0,  0,  0, 0, 0, 2'b00, 0, 2'b10, 3'b010, 0);
        k_ill        = c(0, 0,  0,  0,  0,  0,  0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 1);

        @(posedge clk);
        #1;
        cyc("reset_hold", 32'h0, 0, 1, FETCH, k_fetch_rst, 0);
        reset = 1'b0;

        // addu: FETCH DECODE REXEC RWB
        cyc("addu_fetch",  I_ADDU, 0, 1, FETCH,  k_fetch,     0);
        cyc("addu_decode", I_ADDU, 0, 1, DECODE, k_decode,    0);
        cyc("addu_rexec",  I_ADDU, 0, 1, REXEC,  k_rexec_add, 0);
        cyc("addu_rwb",    I_ADDU, 0, 1, RWB,    k_rwb,       0);

        // lw with two wait cycles in MEMRD
        cyc("lw_fetch",  I_LW, 0, 1, FETCH,  k_fetch,  0);
        cyc("lw_decode", I_LW, 0, 1, DECODE, k_decode, 0);
        cyc("lw_memadr", I_LW, 0, 0, MEMADR, k_memadr, 0);
        cyc("lw_memrd0", I_LW, 0, 0, MEMRD,  k_memrd,  0);
        cyc("lw_memrd1", I_LW, 0, 0, MEMRD,  k_memrd,  0);
        cyc("lw_memrd2", I_LW, 0, 1, MEMRD,  k_memrd,  0);
        cyc("lw_memwb",  I_LW, 0, 1, MEMWB,  k_memwb,  0);

        // beq taken then not taken
        cyc("beq1_fetch",  I_BEQ, 1, 1, FETCH,  k_fetch,  0);
        cyc("beq1_decode", I_BEQ, 1, 1, DECODE, k_decode, 0);
        cyc("beq1_branch", I_BEQ, 1, 1, BRANCH, k_beq1,   0);
        cyc("beq0_fetch",  I_BEQ, 0, 1, FETCH,  k_fetch,  0);
        cyc("beq0_decode", I_BEQ, 0, 1, DECODE, k_decode, 0);
        cyc("beq0_branch", I_BEQ, 0, 1, BRANCH, k_beq0,   0);

        // ori and lui, with a fetch wait before ori
        cyc("ori_fwait",  I_ORI, 0, 0, FETCH,  k_fetch_wait, 0);
        cyc("ori_fetch",  I_ORI, 0, 1, FETCH,  k_fetch,      0);
        cyc("ori_decode", I_ORI, 0, 1, DECODE, k_decode,     0);
        cyc("ori_iexec",  I_ORI, 0, 1, IEXEC,  k_ori,        0);
        cyc("ori_iwb",    I_ORI, 0, 1, IWB,    k_iwb,        0);
        cyc("lui_fetch",  I_LUI, 0, 1, FETCH,  k_fetch,      0);
        cyc("lui_decode", I_LUI, 0, 1, DECODE, k_decode,     0);
        cyc("lui_iexec",  I_LUI, 0, 1, IEXEC,  k_lui,        0);
        cyc("lui_iwb",    I_LUI, 0, 1, IWB,    k_iwb,        0);

        // j
        cyc("j_fetch",  I_J, 0, 1, FETCH,  k_fetch,  0);
        cyc("j_decode", I_J, 0, 1, DECODE, k_decode, 0);
        cyc("j_jump",   I_J, 0, 1, JUMP,   k_jump,   0);

        // sw with one wait in MEMWR
        cyc("sw_fetch",  I_SW, 0, 1, FETCH,  k_fetch,  0);
        cyc("sw_decode", I_SW, 0, 1, DECODE, k_decode, 0);
        cyc("sw_memadr", I_SW, 0, 1, MEMADR, k_memadr, 0);
        cyc("sw_memwr0", I_SW, 0, 0, MEMWR,  k_memwr,  0);
        cyc("sw_memwr1", I_SW, 0, 1, MEMWR,  k_memwr,  0);

        // illegal opcode: terminal until reset
        cyc("badop_fetch",  I_BADOP, 0, 1, FETCH,  k_fetch,  0);
        cyc("badop_decode", I_BADOP, 0, 1, DECODE, k_decode, 0);
        for (int i = 0; i < 10; i++) cyc("badop_illegal", I_BADOP, 1, 1, ILLEGAL, k_ill, 0);
        reset = 1'b1;
        cyc("badop_reset", I_BADOP, 0, 1, FETCH, k_fetch_rst, 0);
        reset = 1'b0;

        // R-type with unsupported funct (slt)
        cyc("slt_fetch",  I_SLT, 0, 1, FETCH,  k_fetch,     0);
        cyc("slt_decode", I_SLT, 0, 1, DECODE, k_decode,    0);
        cyc("slt_rexec",  I_SLT, 0, 1, REXEC,  k_rexec_add, 0);
        for (int i = 0; i < 10; i++) cyc("slt_illegal", I_SLT, 1, 1, ILLEGAL, k_ill, 0);
        reset = 1'b1;
        cyc("slt_reset", I_SLT, 0, 1, FETCH, k_fetch_rst, 0);
        reset = 1'b0;

        // sw aborted by reset while stalled in MEMWR
        cyc("swrst_fetch",  I_SW, 0, 1, FETCH,  k_fetch,  0);
        cyc("swrst_decode", I_SW, 0, 1, DECODE, k_decode, 0);
        cyc("swrst_memadr", I_SW, 0, 0, MEMADR, k_memadr, 0);
        cyc("swrst_memwr",  I_SW, 0, 0, MEMWR,  k_memwr,  0);
        reset = 1'b1;
        cyc("swrst_abort",  I_SW, 0, 0, FETCH,  k_fetch_rst, 0);
        reset = 1'b0;
        cyc("swrst_refetch", I_ADDU, 0, 1, FETCH, k_fetch, 0);

        // Handshake disabled: sw finishes in 4 cycles despite mem_ready tied low
        reset = 1'b1;
        cyc("nr_reset", I_SW, 0, 0, FETCH, k_fetch_rst, 1);
        reset = 1'b0;
        cyc("nr_fetch",  I_SW, 0, 0, FETCH,  k_fetch,  1);
        cyc("nr_decode", I_SW, 0, 0, DECODE, k_decode, 1);
        cyc("nr_memadr", I_SW, 0, 0, MEMADR, k_memadr, 1);
        cyc("nr_memwr",  I_SW, 0, 0, MEMWR,  k_memwr,  1);
        cyc("nr_next",   I_SW, 0, 0, FETCH,  k_fetch,  1);

        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit for the next-generation multicycle MIPS core. It replaces the single-cycle combinational decoder with a Moore state machine that sequences fetch, decode, execute, memory and write-back over several cycles. It shares one memory port between instruction and data accesses, with an optional memory-ready handshake for variable-latency memory. It sits beside the datapath, reading the instruction register and the ALU zero flag and driving every mux select and write enable.

Parameters:
USE_MEM_READY, 1, 1: memory states wait for mem_ready; 0: mem_ready ignored and treated as 1
ALUCTRL_W, 3, width of alucontrol
STATE_W, 4, width of the debug state output

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
instr  in  32  instruction register contents (stable after irwrite)
zero  in  1  ALU result is zero
mem_ready  in  1  memory completes the current access this cycle
pcen  out  1  PC write enable
irwrite  out  1  instruction register write enable
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
memread  out  1  memory read strobe
memwrite  out  1  memory write strobe
memtoreg  out  1  register write data select: 1 = memory data, 0 = ALUOut
regwrite  out  1  register file write enable
regdst  out  1  destination register select: 1 = instr[15:11], 0 = instr[20:16]
alusrca  out  1  ALU operand A select: 0 = PC, 1 = rs
alusrcb  out  2  ALU operand B select: 00 = rt, 01 = constant 4, 10 = immediate, 11 = immediate<<2
immext  out  1  immediate extension: 0 = sign-extend, 1 = zero-extend
pcsrc  out  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target
alucontrol  out  ALUCTRL_W  ALU operation code
illegal  out  1  sticky flag: undecodable instruction seen
state  out  STATE_W  current state, debug only

Behaviour:
- Registered state; all outputs are combinational from state, except where noted. Any output not listed for a state is 0; alucontrol defaults to 010.
- ALU codes: add 010, sub 110, and 000, or 001, sltu 111, lui 011.
- Reset: state becomes FETCH asynchronously, illegal clears to 0. While reset is high, pcen, irwrite, memread, memwrite and regwrite are forced to 0.
- FETCH: memread=1, alusrcb=01, add. pcen and irwrite equal mem_ready. Go to DECODE on mem_ready, otherwise hold.
- DECODE: alusrcb=11, add (precomputes the branch target into ALUOut). Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> REXEC
  - 000100 (beq) -> BRANCH
  - 001001 (addiu), 001101 (ori), 001111 (lui) -> IEXEC
  - 000010 (j) -> JUMP
  - any other op -> ILLEGAL
- MEMADR: alusrca=1, alusrcb=10, add. Go to MEMRD if op[3]=0, MEMWR if op[3]=1.
- MEMRD: iord=1, memread=1. Hold until mem_ready, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
- MEMWR: iord=1, memwrite=1. memwrite stays asserted until the mem_ready cycle, then FETCH.
- REXEC: alusrca=1, alusrcb=00, alucontrol from funct: 100001 add, 100011 sub, 100100 and, 100101 or, 101011 sltu. A known funct goes to RWB; an unknown funct goes to ILLEGAL.
- RWB: regwrite=1, regdst=1 -> FETCH.
- IEXEC: alusrca=1, alusrcb=10. addiu: add, immext=0. ori: or, immext=1. lui: lui code, immext=1. Next IWB.
- IWB: regwrite=1, regdst=0 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero (Mealy on zero) -> FETCH.
- JUMP: pcsrc=10, pcen=1 -> FETCH.
- ILLEGAL: all strobes 0, illegal=1. Terminal state; only reset leaves it.
- CPI: lw 5, sw 4, R-type/I-type 4, beq 3, j 3, each plus memory wait cycles.
- Reset asserted mid-access (e.g. in MEMWR) aborts the access immediately; no write strobe survives the reset edge.
- With USE_MEM_READY=0, every memory state lasts exactly one cycle regardless of mem_ready.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct constants
  - ALU code constants
  - the state enumeration (13 states, fits STATE_W=4)
  - alusrcb and pcsrc encodings
- One natural sub-module: alu_decoder, the combinational funct -> alucontrol plus funct_valid decoder, instantiated for REXEC.

Test Plan:
- Reset, then addu $3,$1,$2 (0x00221821) with mem_ready=1 -> states FETCH, DECODE, REXEC, RWB, FETCH; alucontrol=010 in REXEC; regwrite=1, regdst=1 in RWB.
- lw (0x8C220004) with mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles, iord=1 throughout, then MEMWB with memtoreg=1, regwrite=1.
- beq with zero=1, then zero=0 -> pcen=1 / pcsrc=01 in BRANCH for the first, pcen=0 for the second; back to FETCH after 3 cycles each.
- ori (0x34220FF0) -> immext=1 and alucontrol=001 in IEXEC. lui (0x3C011234) -> alucontrol=011.
- Opcode 0x3F, and R-type funct 0x2A -> ILLEGAL entered, illegal=1 and all strobes 0 for 10 cycles; reset clears it and returns to FETCH.
- sw with reset asserted in MEMWR -> memwrite drops in the same cycle, state=FETCH, then normal fetch after reset release. With USE_MEM_READY=0 and mem_ready tied 0 -> sw completes in 4 cycles.
